am_envelope_detector: RTL and testbench

- Receive-side counterpart of the amplitude modulator: recovers the modulating envelope from an AM-modulated 8-bit sample stream.
- Uses windowed peak-to-peak detection: tracks max and min over a run-time-selectable number of accepted samples and emits max-min once per window.
- Optional 2-tap smoothing of successive results.
- Sits after the modulator or any sample source; drives amplitude meters, AGC logic or a re-modulation stage.

---
 rtl/am_envelope_detector.sv | 115 +++++++++++
 tb/tb_am_envelope_detector.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/am_envelope_detector.sv
// Windowed peak-to-peak envelope detector for an unsigned AM sample stream.
// Each window reports max-min of its samples, optionally averaged with the previous result.
module am_envelope_detector #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter int SMOOTH = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_data_i,
  input  logic [CNT_W-1:0]  window_len_i,
  output logic [DATA_W-1:0] amplitude_o,
  output logic              amplitude_valid_o
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    win_len_q, win_len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [DATA_W-1:0]   min_q, min_d;
  logic                first_q, first_d;
  logic [DATA_W-1:0]   amp_q, amp_d;
  logic                vld_q, vld_d;

  logic [CNT_W-1:0]    len_eff;
  logic [CNT_W-1:0]    cnt_inc;
  logic                win_close;
  logic [DATA_W-1:0]   pp;

  // Rounded mean of two amplitudes; the extra sum bit keeps the carry.
  function automatic logic [DATA_W-1:0] round_mean(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, 1'b1};
    return sum[DATA_W:1];
  endfunction

  assign len_eff   = (window_len_i == '0) ? CNT_ONE : window_len_i;
  assign cnt_inc   = cnt_q + CNT_ONE;
  assign win_close = sample_valid_i &&
                     ((state_q == IDLE) ? (len_eff == CNT_ONE) : (cnt_inc == win_len_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      win_len_q <= CNT_ONE;
      cnt_q     <= '0;
      max_q     <= '0;
      min_q     <= '1;
      first_q   <= 1'b1;
      amp_q     <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_len_q <= win_len_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      min_q     <= min_d;
      first_q   <= first_d;
      amp_q     <= amp_d;
      vld_q     <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sample_valid_i) begin
      state_d = win_close ? IDLE : ACCUM;
    end
  end

  // Extremes are updated including the current sample so pp covers the closing sample.
  always_comb begin
    win_len_d = win_len_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    min_d     = min_q;
    first_d   = first_q;
    amp_d     = amp_q;
    vld_d     = win_close;
    if (sample_valid_i) begin
      if (state_q == IDLE) begin
        win_len_d = len_eff;
        cnt_d     = CNT_ONE;
        max_d     = sample_data_i;
        min_d     = sample_data_i;
      end else begin
        cnt_d = cnt_inc;
        max_d = (sample_data_i > max_q) ? sample_data_i : max_q;
        min_d = (sample_data_i < min_q) ? sample_data_i : min_q;
      end
    end
    pp = max_d - min_d;
    if (win_close) begin
      cnt_d = '0;
      if ((SMOOTH != 0) && !first_q) begin
        amp_d = round_mean(amp_q, pp);
      end else begin
        amp_d = pp;
      end
      if (SMOOTH != 0) begin
        first_d = 1'b0;
      end
    end
  end

  assign amplitude_o       = amp_q;
  assign amplitude_valid_o = vld_q;

endmodule

// File: tb/tb_am_envelope_detector.sv
// Bench for am_envelope_detector: raw and smoothed instances share one stimulus stream
// and are compared every cycle against a window/queue reference model.
module tb_am_envelope_detector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v = 1'b0;
  logic [7:0]  d = '0;
  logic [15:0] len = 16'd1;
  logic [7:0]  amp0, amp1;
  logic        vld0, vld1;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model state
  bit m_open = 1'b0;
  int m_len = 1;
  int m_q[$];
  bit m_first = 1'b1;
  int e_amp0 = 0, e_amp1 = 0;
  bit e_vld = 1'b0;

  always #5 clk = ~clk;

  am_envelope_detector #(.DATA_W(8), .CNT_W(16), .SMOOTH(0)) u_raw (
    .clk_i(clk), .rst_i(rst), .sample_valid_i(v), .sample_data_i(d),
    .window_len_i(len), .amplitude_o(amp0), .amplitude_valid_o(vld0));

  am_envelope_detector #(.DATA_W(8), .CNT_W(16), .SMOOTH(1)) u_smooth (
    .clk_i(clk), .rst_i(rst), .sample_valid_i(v), .sample_data_i(d),
    .window_len_i(len), .amplitude_o(amp1), .amplitude_valid_o(vld1));

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    tests++;
    if (act < exp - tol || act > exp + tol) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d at %0t", name, act, exp, tol, $time);
    end
  endtask

  // Model of one clock edge, using the inputs present at that edge.
  task automatic model_edge();
    int mx, mn, pp;
    if (rst) begin
      m_open = 1'b0; m_q.delete(); m_first = 1'b1;
      e_amp0 = 0; e_amp1 = 0; e_vld = 1'b0;
      return;
    end
    e_vld = 1'b0;
    if (!v) return;
    if (!m_open) begin
      m_len = (len == 0) ? 1 : int'(len);
      m_open = 1'b1;
      m_q.delete();
    end
    m_q.push_back(int'(d));
    if (m_q.size() == m_len) begin
      mx = 0; mn = 255;
      foreach (m_q[i]) begin
        if (m_q[i] > mx) mx = m_q[i];
        if (m_q[i] < mn) mn = m_q[i];
      end
      pp = mx - mn;
      e_amp0 = pp;
      e_amp1 = m_first ? pp : (e_amp1 + pp + 1) / 2;
      m_first = 1'b0;
      e_vld = 1'b1;
      m_open = 1'b0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit vv, input int dd);
    v = vv;
    d = 8'(dd);
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; v = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("raw_amp", int'(amp0), e_amp0);
      check("raw_vld", int'(vld0), int'(e_vld));
      check("smooth_amp", int'(amp1), e_amp1);
      check("smooth_vld", int'(vld1), int'(e_vld));
    end
  end

  int carrier[8] = '{0, 90, 127, 90, 0, -90, -128, -90};

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("reset_amp", int'(amp0), 0);
    check("reset_vld", int'(vld0), 0);

    // Basic window and smoothing sequence
    len = 16'd4;
    drive(1, 10); drive(1, 200); drive(1, 50); drive(1, 100);
    check("basic_amp", int'(amp0), 190);
    check("basic_vld", int'(vld0), 1);
    check("smooth_w1", int'(amp1), 190);
    drive(0, 0);
    check("basic_vld_drop", int'(vld0), 0);
    check("basic_hold", int'(amp0), 190);
    for (int i = 0; i < 4; i++) drive(1, 100);
    check("smooth_w2", int'(amp1), 95);
    check("raw_w2", int'(amp0), 0);
    drive(1, 0); drive(1, 255); drive(1, 0); drive(1, 255);
    check("smooth_w3", int'(amp1), 175);

    // Degenerate window length
    do_reset();
    len = 16'd0;
    drive(1, 7);  check("deg_a", int'(amp0), 0); check("deg_va", int'(vld0), 1);
    drive(1, 99); check("deg_b", int'(amp0), 0); check("deg_vb", int'(vld0), 1);
    drive(1, 3);  check("deg_c", int'(amp0), 0); check("deg_vc", int'(vld0), 1);
    len = 16'd2;
    drive(1, 0);  check("len2_mid_vld", int'(vld0), 0);
    drive(1, 255); check("len2_amp", int'(amp0), 255);

    // Gapped strobes with a mid-window length change
    do_reset();
    len = 16'd3;
    drive(1, 40);
    len = 16'd8;
    drive(0, 0); drive(0, 0); drive(1, 120);
    drive(0, 0); drive(0, 0); drive(1, 80);
    check("gap_amp", int'(amp0), 80);
    check("gap_vld", int'(vld0), 1);
    for (int i = 0; i < 7; i++) drive(1, 20 + 10 * i);
    check("len8_not_done", int'(vld0), 0);
    drive(1, 5);
    check("len8_amp", int'(amp0), 75);

    // Reset mid-window discards partial data
    do_reset();
    len = 16'd4;
    drive(1, 0); drive(1, 250);
    do_reset();
    check("rst_mid_amp", int'(amp0), 0);
    drive(1, 60); drive(1, 70); drive(1, 65); drive(1, 62);
    check("rst_mid_res", int'(amp0), 10);

    // AM end-to-end: envelope 128 on a full-scale carrier, window = one period
    do_reset();
    len = 16'd8;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 8; k++) drive(1, 128 + ((carrier[k] * 128) >>> 8));
      check_near("am_raw", int'(amp0), 127, 2);
      check_near("am_smooth", int'(amp1), 127, 2);
    end

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 9) == 0)
          len = 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 1) : $urandom_range(2, 9));
        drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)));
      end
    end
    v = 1'b0;
    cyc(); cyc();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
